// File: rtl/rmt_pkt_arb.sv
// rmt_pkt_arb: packet-granular round-robin arbiter merging PORT_COUNT
// AXI-Stream sources into one registered stream toward the RMT parser.
// A source keeps the output from grant until its tlast beat is taken, and
// every forwarded beat is tagged with the index of the source it came from.

module rmt_pkt_arb #(
    parameter int PORT_COUNT = 2,
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORT_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORT_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [PORT_COUNT-1:0]            s_axis_tvalid,
    output logic [PORT_COUNT-1:0]            s_axis_tready,
    input  logic [PORT_COUNT-1:0]            s_axis_tlast,
    input  logic [PORT_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic [ID_WIDTH-1:0]              m_axis_tid,
    output logic [31:0]                      stat_pkt_count,
    output logic                             busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(PORT_COUNT - 1);

    // Modular add of an offset onto a source index (offset < PORT_COUNT).
    function automatic logic [ID_WIDTH-1:0] idx_add(
        input logic [ID_WIDTH-1:0] base,
        input int                  off
    );
        int sum;
        sum = int'(base) + off;
        if (sum >= PORT_COUNT) begin
            sum = sum - PORT_COUNT;
        end else begin
            sum = sum;
        end
        return ID_WIDTH'(sum);
    endfunction

    // Registered state
    logic                  rst_sync_r;
    state_t                state_r;
    logic [ID_WIDTH-1:0]   grant_r;
    logic [ID_WIDTH-1:0]   last_grant_r;
    logic                  m_valid_r;
    logic                  m_last_r;
    logic [DATA_WIDTH-1:0] m_data_r;
    logic [KEEP_WIDTH-1:0] m_keep_r;
    logic [USER_WIDTH-1:0] m_user_r;
    logic [ID_WIDTH-1:0]   m_tid_r;
    logic [31:0]           stat_cnt_r;

    // Combinational signals
    state_t                state_nx_s;
    logic [ID_WIDTH-1:0]   grant_nx_s;
    logic [ID_WIDTH-1:0]   last_grant_nx_s;
    logic [ID_WIDTH-1:0]   start_s;
    logic [PORT_COUNT-1:0] req_rot_s;
    logic [ID_WIDTH-1:0]   winner_s;
    logic                  any_req_s;
    logic [PORT_COUNT-1:0] gnt_oh_s;
    logic                  sel_valid_s;
    logic                  sel_last_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [KEEP_WIDTH-1:0] sel_keep_s;
    logic [USER_WIDTH-1:0] sel_user_s;
    logic                  busy_s;
    logic                  out_room_s;
    logic                  s_fire_s;
    logic                  m_fire_s;

    assign busy_s     = (state_r == ST_BUSY);
    assign out_room_s = !m_valid_r || m_axis_tready;
    assign s_fire_s   = busy_s && sel_valid_s && out_room_s;
    assign m_fire_s   = m_valid_r && m_axis_tready;

    // Reset is applied asynchronously but released only on a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_r <= 1'b0;
        end else begin
            rst_sync_r <= 1'b1;
        end
    end

    // Round-robin search: rotate the requests so the slot after the last
    // grant sits at bit 0, then take the lowest set bit.
    always_comb begin
        start_s   = (last_grant_r == LAST_IDX) ? '0 : last_grant_r + ID_WIDTH'(1);
        req_rot_s = PORT_COUNT'({s_axis_tvalid, s_axis_tvalid} >> start_s);
        any_req_s = |s_axis_tvalid;
        winner_s  = start_s;
        for (int k = PORT_COUNT - 1; k >= 0; k--) begin
            winner_s = req_rot_s[k] ? idx_add(start_s, k) : winner_s;
        end
    end

    // Steer the granted source onto the internal beat bus and drive its ready;
    // ready never looks at any tvalid.
    always_comb begin
        sel_valid_s   = 1'b0;
        sel_last_s    = 1'b0;
        sel_data_s    = '0;
        sel_keep_s    = '0;
        sel_user_s    = '0;
        s_axis_tready = '0;
        gnt_oh_s      = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            gnt_oh_s[i]      = (grant_r == ID_WIDTH'(i));
            sel_valid_s      = sel_valid_s | (s_axis_tvalid[i] & gnt_oh_s[i]);
            sel_last_s       = sel_last_s  | (s_axis_tlast[i]  & gnt_oh_s[i]);
            sel_data_s       = sel_data_s
                             | (s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt_oh_s[i]}});
            sel_keep_s       = sel_keep_s
                             | (s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] & {KEEP_WIDTH{gnt_oh_s[i]}});
            sel_user_s       = sel_user_s
                             | (s_axis_tuser[i*USER_WIDTH +: USER_WIDTH] & {USER_WIDTH{gnt_oh_s[i]}});
            s_axis_tready[i] = busy_s & gnt_oh_s[i] & out_room_s;
        end
    end

    // Next-state logic: grant in IDLE, release after the granted tlast is taken.
    always_comb begin
        state_nx_s      = state_r;
        grant_nx_s      = grant_r;
        last_grant_nx_s = last_grant_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nx_s      = ST_BUSY;
                    grant_nx_s      = winner_s;
                    last_grant_nx_s = winner_s;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (s_fire_s && sel_last_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= LAST_IDX;
        end else if (!rst_sync_r) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= LAST_IDX;
        end else begin
            state_r      <= state_nx_s;
            grant_r      <= grant_nx_s;
            last_grant_r <= last_grant_nx_s;
        end
    end

    // Single output register stage; holds its beat while downstream stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_data_r  <= '0;
            m_keep_r  <= '0;
            m_user_r  <= '0;
            m_tid_r   <= '0;
        end else if (!rst_sync_r) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_data_r  <= '0;
            m_keep_r  <= '0;
            m_user_r  <= '0;
            m_tid_r   <= '0;
        end else if (out_room_s) begin
            m_valid_r <= s_fire_s;
            if (s_fire_s) begin
                m_last_r <= sel_last_s;
                m_data_r <= sel_data_s;
                m_keep_r <= sel_keep_s;
                m_user_r <= sel_user_s;
                m_tid_r  <= grant_r;
            end
        end
    end

    // Count packets whose last beat is taken downstream; wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_cnt_r <= 32'd0;
        end else if (!rst_sync_r) begin
            stat_cnt_r <= 32'd0;
        end else if (m_fire_s && m_last_r) begin
            stat_cnt_r <= stat_cnt_r + 32'd1;
        end
    end

    assign m_axis_tvalid  = m_valid_r;
    assign m_axis_tlast   = m_last_r;
    assign m_axis_tdata   = m_data_r;
    assign m_axis_tkeep   = m_keep_r;
    assign m_axis_tuser   = m_user_r;
    assign m_axis_tid     = m_tid_r;
    assign stat_pkt_count = stat_cnt_r;
    assign busy           = busy_s;

endmodule
